// File: rtl/ql_bus_timing_if.sv
// Bus-timing bundle: CPU speed/reset requests in, QL clock enables
// and CPU qualifiers out.
interface ql_bus_timing_if;
    logic [1:0] speed;
    logic       reset_req;
    logic       cpu_idle;
    logic       ce_p;
    logic       ce_n;
    logic       ce_vid;
    logic       ce_sd;
    logic       ce_131k;
    logic       ce_bus_p;
    logic       ce_bus_n;
    logic       cpu_cycle;
    logic       cpu_enable;
    logic       reset_out;

    modport master (
        input  speed, reset_req, cpu_idle,
        output ce_p, ce_n, ce_vid, ce_sd, ce_131k,
        output ce_bus_p, ce_bus_n, cpu_cycle, cpu_enable, reset_out
    );

    modport slave (
        output speed, reset_req, cpu_idle,
        input  ce_p, ce_n, ce_vid, ce_sd, ce_131k,
        input  ce_bus_p, ce_bus_n, cpu_cycle, cpu_enable, reset_out
    );
endinterface

// File: rtl/ql_bus_timing.sv
// QL clock-enable generator: 68008 bus phases, CPU access windows,
// video/SD/RTC strobes and stretched system reset.
module ql_bus_timing #(
    parameter int DIV131K   = 640,
    parameter int RESET_LEN = 4095
) (
    input  logic              clk,
    input  logic              reset_n,
    ql_bus_timing_if.master   bus
);

    localparam int CW = $clog2(RESET_LEN + 1);
    localparam logic [9:0]    L_DIV = 10'(DIV131K);
    localparam logic [CW-1:0] L_RST = CW'(RESET_LEN);

    logic [4:0]    r_div;
    logic [9:0]    r_div131k;
    logic [1:0]    r_speed_q;
    logic          r_duty;
    logic          r_sub;
    logic          r_cpu_en;
    logic [CW-1:0] r_cnt;
    logic          r_ce_p;
    logic          r_ce_n;
    logic          r_ce_vid;
    logic          r_ce_sd;
    logic          r_ce_131k;

    logic          w_duty_nxt;
    logic          w_ce_bus_p;
    logic          w_ce_bus_n;
    logic          w_cpu_cycle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div     <= '0;
            r_div131k <= '0;
            r_ce_p    <= 1'b0;
            r_ce_n    <= 1'b0;
            r_ce_vid  <= 1'b0;
            r_ce_sd   <= 1'b0;
            r_ce_131k <= 1'b0;
        end else begin
            r_div     <= r_div + 5'd1;
            r_div131k <= (r_div131k == L_DIV) ? 10'd0 : r_div131k + 10'd1;
            r_ce_p    <= (r_div[2:0] == 3'd0);
            r_ce_n    <= (r_div[2:0] == 3'd4);
            r_ce_vid  <= (r_div[2:0] == 3'd0);
            r_ce_sd   <= (r_div[1:0] == 2'd0);
            r_ce_131k <= (r_div131k == 10'd0);
        end
    end

    always_comb begin
        w_duty_nxt = 1'b1;
        case (r_speed_q)
            2'd0:    w_duty_nxt = (r_div[4:3] == 2'd0);
            2'd1:    w_duty_nxt = ~r_div[3];
            default: w_duty_nxt = 1'b1;
        endcase
    end

    // speed is only sampled at the end of a 32-clock frame so a window
    // never changes shape half way through
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_speed_q <= 2'd0;
            r_duty    <= 1'b0;
            r_sub     <= 1'b0;
        end else begin
            if (r_div == 5'd31)
                r_speed_q <= bus.speed;
            if (r_div[2:0] == 3'd0)
                r_duty <= w_duty_nxt;
            if (r_div == 5'd0)
                r_sub <= ~r_sub | (r_speed_q != 2'd0);
        end
    end

    assign w_ce_bus_p  = r_duty & r_ce_p;
    assign w_ce_bus_n  = r_duty & r_ce_n;
    assign w_cpu_cycle = r_duty & r_sub;

    // idle bus states may advance in the video sub-cycle; real accesses stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cpu_en <= 1'b0;
        else if (w_ce_bus_n)
            r_cpu_en <= w_cpu_cycle | bus.cpu_idle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= L_RST;
        else if (bus.reset_req)
            r_cnt <= L_RST;
        else if (w_ce_bus_p && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign bus.ce_p       = r_ce_p;
    assign bus.ce_n       = r_ce_n;
    assign bus.ce_vid     = r_ce_vid;
    assign bus.ce_sd      = r_ce_sd;
    assign bus.ce_131k    = r_ce_131k;
    assign bus.ce_bus_p   = w_ce_bus_p;
    assign bus.ce_bus_n   = w_ce_bus_n;
    assign bus.cpu_cycle  = w_cpu_cycle;
    assign bus.cpu_enable = r_cpu_en;
    assign bus.reset_out  = (r_cnt != '0);

endmodule

// File: tb/tb_ql_bus_timing.sv
// Bench for ql_bus_timing: per-cycle expected outputs from a timing
// model are queued at drive time and compared at the falling edge.
module tb_ql_bus_timing;

    localparam int DIV  = 640;
    localparam int RLEN = 4095;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    ql_bus_timing_if bus_if ();

    ql_bus_timing #(
        .DIV131K   (DIV),
        .RESET_LEN (RLEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    int         m_n;
    logic       m_sub;
    logic [1:0] m_spdl;
    logic [1:0] m_ws;
    int         m_cnt;
    logic       m_en;
    logic       p_busp;
    logic       p_busn;
    logic       p_cyc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] obs();
        return {bus_if.ce_p, bus_if.ce_n, bus_if.ce_vid, bus_if.ce_sd,
                bus_if.ce_131k, bus_if.ce_bus_p, bus_if.ce_bus_n,
                bus_if.cpu_cycle, bus_if.cpu_enable, bus_if.reset_out};
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_sub  = 1'b0;
        m_spdl = 2'd0;
        m_ws   = 2'd0;
        m_cnt  = RLEN;
        m_en   = 1'b0;
        p_busp = 1'b0;
        p_busn = 1'b0;
        p_cyc  = 1'b0;
    endtask

    // predict the outputs after the coming edge, queue them, take the edge
    task automatic step();
        int   d;
        logic cp, cn, sd, c131, duty, bp, bn, cyc;
        exp_t e;
        m_n++;
        d = (m_n - 1) % 32;
        if (bus_if.reset_req)
            m_cnt = RLEN;
        else if (p_busp && m_cnt != 0)
            m_cnt--;
        if (p_busn)
            m_en = p_cyc | bus_if.cpu_idle;
        if (d == 0) begin
            m_ws  = m_spdl;
            m_sub = (m_ws != 2'd0) ? 1'b1 : ~m_sub;
        end
        if (d == 31)
            m_spdl = bus_if.speed;
        cp   = (d % 8 == 0);
        cn   = (d % 8 == 4);
        sd   = (d % 4 == 0);
        c131 = ((m_n - 1) % (DIV + 1) == 0);
        case (m_ws)
            2'd0:    duty = (d < 8);
            2'd1:    duty = ((d / 8) % 2 == 0);
            default: duty = 1'b1;
        endcase
        bp  = duty & cp;
        bn  = duty & cn;
        cyc = duty & m_sub;
        e.n = m_n;
        e.v = {cp, cn, cp, sd, c131, bp, bn, cyc, m_en, (m_cnt != 0)};
        sb.push_back(e);
        p_busp = bp;
        p_busn = bn;
        p_cyc  = cyc;
        @(posedge clk);
        #1;
        bus_if.cpu_idle = 1'($urandom_range(0, 1));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("outs@%0d", e.n), 32'(obs()), 32'(e.v));
        end
    end

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk({tag, "_asserted"}, 32'(obs()), 32'(10'b1));
        repeat (2) @(posedge clk);
        #1 chk({tag, "_held"}, 32'(obs()), 32'(10'b1));
        @(negedge clk);
        #1 reset_n = 1'b1;
        #1 chk({tag, "_pre_edge1"}, 32'(obs()), 32'(10'b1));
        model_reset();
    endtask

    initial begin
        int hi;
        bus_if.speed     = 2'd0;
        bus_if.reset_req = 1'b0;
        bus_if.cpu_idle  = 1'b0;
        model_reset();

        reset_pulse("por");
        repeat (700) step();

        // a short speed blip inside a frame must leave the pattern alone
        while (m_n % 32 != 13) step();
        bus_if.speed = 2'd1;
        repeat (7) step();
        bus_if.speed = 2'd0;
        repeat (64) step();

        while (m_n % 32 != 13) step();
        bus_if.speed = 2'd1;
        repeat (100) step();
        bus_if.speed = 2'd2;
        repeat (100) step();
        bus_if.speed = 2'd3;
        repeat (40) step();
        bus_if.speed = 2'd2;
        repeat (80) step();

        // land each request on an edge that also sees ce_bus_p
        while (m_n % 8 != 1) step();
        bus_if.reset_req = 1'b1;
        step();
        bus_if.reset_req = 1'b0;
        repeat (799) step();
        bus_if.reset_req = 1'b1;
        step();
        bus_if.reset_req = 1'b0;
        hi = 0;
        while (bus_if.reset_out === 1'b1 && hi < 40000) begin
            hi++;
            step();
        end
        chk("stretch_len", 32'(hi), 32'(RLEN * 8));
        repeat (20) step();

        reset_pulse("mid");
        repeat (700) step();

        @(negedge clk);
        #1 chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
